seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_down_cnt.sv | 26 ++
 rtl/seq_gen.sv | 132 +++++++++++++
 tb/tb_seq_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: state encoding and
// default pattern parameters.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          DEF_SEQ_LEN = 7;
  localparam logic [31:0] DEF_SEQ     = 32'b1110010;
  localparam int          DEF_GAP_LEN = 2;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_gen.sv
// Burst serial pattern generator: sends SEQ MSB first, rep_cnt times per burst,
// with GAP_LEN fill cycles between repetitions and a one-cycle done pulse.
module seq_gen
  import seq_pkg::*;
#(
  parameter int                 SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ[SEQ_LEN-1:0],
  parameter int                 GAP_LEN = DEF_GAP_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rep_cnt,
  input  logic       abort,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  localparam int              BW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [BW-1:0]   BIT_TOP = BW'(SEQ_LEN - 1);
  localparam logic [3:0]      GAP_TOP = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;

  state_t state_reg, state_next;

  logic          bit_load, bit_dec, bit_zero;
  logic [BW-1:0] bit_val, bit_count;
  logic          rep_load, rep_dec, rep_zero;
  logic [3:0]    rep_val, unused_rep_count;
  logic          gap_load, gap_dec, gap_zero;
  logic [3:0]    gap_val, unused_gap_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The repetition counter holds repetitions still owed after the current one.
  always_comb begin
    state_next = state_reg;
    bit_load   = 1'b0;
    bit_val    = BIT_TOP;
    bit_dec    = 1'b0;
    rep_load   = 1'b0;
    rep_val    = (rep_cnt == 4'd0) ? 4'd0 : rep_cnt - 4'd1;
    rep_dec    = 1'b0;
    gap_load   = 1'b0;
    gap_val    = GAP_TOP;
    gap_dec    = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
      bit_load   = 1'b1;
      bit_val    = '0;
      rep_load   = 1'b1;
      rep_val    = 4'd0;
      gap_load   = 1'b1;
      gap_val    = 4'd0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_next = ST_SEND;
            bit_load   = 1'b1;
            rep_load   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (!bit_zero) begin
            bit_dec = 1'b1;
          end else if (rep_zero) begin
            state_next = ST_DONE;
          end else begin
            rep_dec = 1'b1;
            if (GAP_LEN > 0) begin
              state_next = ST_GAP;
              gap_load   = 1'b1;
            end else begin
              bit_load = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_zero) begin
            state_next = ST_SEND;
            bit_load   = 1'b1;
          end else begin
            gap_dec = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  seq_down_cnt #(.W(BW)) u_bit_cnt (
    .clk(clk), .reset(reset), .load(bit_load), .load_val(bit_val),
    .dec(bit_dec), .count(bit_count), .zero(bit_zero)
  );

  seq_down_cnt #(.W(4)) u_rep_cnt (
    .clk(clk), .reset(reset), .load(rep_load), .load_val(rep_val),
    .dec(rep_dec), .count(unused_rep_count), .zero(rep_zero)
  );

  seq_down_cnt #(.W(4)) u_gap_cnt (
    .clk(clk), .reset(reset), .load(gap_load), .load_val(gap_val),
    .dec(gap_dec), .count(unused_gap_count), .zero(gap_zero)
  );

  // Outputs decode registered state only, so start never reaches them combinationally.
  always_comb begin
    out = 1'b0;
    case (state_reg)
      ST_SEND: out = SEQ[bit_count];
      ST_GAP:  out = ~SEQ[SEQ_LEN-1];
      default: out = 1'b0;
    endcase
  end

  assign valid = (state_reg == ST_SEND);
  assign busy  = (state_reg == ST_SEND) || (state_reg == ST_GAP);
  assign done  = (state_reg == ST_DONE);
  assign state = state_reg;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: vector table, loopback detector, async reset
// sequence and a randomized run against a queue-based burst model.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [3:0] rep_cnt = 4'd0;
  logic       out, valid, busy, done;
  logic [1:0] state;

  logic       start0 = 1'b0, abort0 = 1'b0;
  logic [3:0] rep_cnt0 = 4'd0;
  logic       out0, valid0, busy0, done0;
  logic [1:0] state0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_gen dut (
    .clk(clk), .reset(reset), .start(start), .rep_cnt(rep_cnt), .abort(abort),
    .out(out), .valid(valid), .busy(busy), .done(done), .state(state)
  );

  seq_gen #(.GAP_LEN(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .rep_cnt(rep_cnt0), .abort(abort0),
    .out(out0), .valid(valid0), .busy(busy0), .done(done0), .state(state0)
  );

  // Expected-output word layout: {out, valid, busy, done, state[1:0]}
  localparam logic [5:0] IDLE_E = 6'b000000;
  localparam logic [5:0] GAP_E  = 6'b001010;
  localparam logic [5:0] DONE_E = 6'b000111;

  logic [6:0] pat = 7'b1110010;

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] rep;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] send_e(input logic b);
    return {b, 1'b1, 1'b1, 1'b0, 2'b01};
  endfunction

  function automatic logic [5:0] act_main();
    return {out, valid, busy, done, state};
  endfunction

  task automatic add(input logic s, input logic a, input logic [3:0] r, input logic [5:0] x);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.rep   = r;
    v.exp   = x;
    tbl.push_back(v);
  endtask

  task automatic add_bits_after_msb();
    for (int b = 5; b >= 0; b--) add(1'b0, 1'b0, 4'd0, send_e(pat[b]));
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Burst model: the whole cycle-by-cycle output of a burst, from the rules.
  logic [5:0] mq[$];

  task automatic build_burst(input logic [3:0] r);
    int reps;
    reps = (r == 4'd0) ? 1 : int'(r);
    mq.delete();
    for (int k = 0; k < reps; k++) begin
      for (int b = 6; b >= 0; b--) mq.push_back(send_e(pat[b]));
      if (k < reps - 1) begin
        for (int g = 0; g < 2; g++) mq.push_back({~pat[6], 5'b01010});
      end
    end
    mq.push_back(DONE_E);
  endtask

  initial begin
    logic [5:0] cur;
    logic [6:0] sr;
    int         pulses, done_cyc, n;
    int         pulse_at[$];
    logic       s, a;
    logic [3:0] r;

    // Reset state while held
    #12;
    check("reset_main", 32'(act_main()), 32'(IDLE_E));
    check("reset_lb", 32'({out0, valid0, busy0, done0, state0}), 32'(IDLE_E));
    @(negedge clk);
    reset = 1'b1;

    // Single repetition; a start held mid-burst must be ignored
    add(1'b1, 1'b0, 4'd1, send_e(pat[6]));
    for (int b = 5; b >= 0; b--) add(b == 3, 1'b0, 4'd7, send_e(pat[b]));
    add(1'b0, 1'b0, 4'd0, DONE_E);
    add(1'b0, 1'b0, 4'd0, IDLE_E);
    // rep_cnt=0 acts as 1; start in DONE restarts with no IDLE cycle
    add(1'b1, 1'b0, 4'd0, send_e(pat[6]));
    add_bits_after_msb();
    add(1'b0, 1'b0, 4'd0, DONE_E);
    add(1'b1, 1'b0, 4'd1, send_e(pat[6]));
    add_bits_after_msb();
    add(1'b0, 1'b0, 4'd0, DONE_E);
    add(1'b0, 1'b0, 4'd0, IDLE_E);
    // Two repetitions with a two-cycle gap
    add(1'b1, 1'b0, 4'd2, send_e(pat[6]));
    add_bits_after_msb();
    add(1'b0, 1'b0, 4'd0, GAP_E);
    add(1'b0, 1'b0, 4'd0, GAP_E);
    add(1'b0, 1'b0, 4'd0, send_e(pat[6]));
    add_bits_after_msb();
    add(1'b0, 1'b0, 4'd0, DONE_E);
    add(1'b0, 1'b0, 4'd0, IDLE_E);
    // Abort in the fourth SEND cycle, with start held throughout
    add(1'b1, 1'b0, 4'd5, send_e(pat[6]));
    add(1'b1, 1'b0, 4'd5, send_e(pat[5]));
    add(1'b0, 1'b0, 4'd5, send_e(pat[4]));
    add(1'b1, 1'b0, 4'd5, send_e(pat[3]));
    add(1'b1, 1'b1, 4'd5, IDLE_E);
    add(1'b0, 1'b0, 4'd0, IDLE_E);
    add(1'b1, 1'b1, 4'd3, IDLE_E);
    add(1'b0, 1'b0, 4'd0, IDLE_E);
    // Abort beats a start offered in DONE
    add(1'b1, 1'b0, 4'd1, send_e(pat[6]));
    add_bits_after_msb();
    add(1'b0, 1'b0, 4'd0, DONE_E);
    add(1'b1, 1'b1, 4'd1, IDLE_E);
    add(1'b0, 1'b0, 4'd0, IDLE_E);

    foreach (tbl[i]) begin
      start   = tbl[i].start;
      abort   = tbl[i].abort;
      rep_cnt = tbl[i].rep;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(act_main()), 32'(tbl[i].exp));
      $display("vec %0d start=%0b abort=%0b rep=%0d -> %b", i, tbl[i].start, tbl[i].abort, tbl[i].rep, act_main());
    end
    start = 1'b0; abort = 1'b0; rep_cnt = 4'd0;

    // Loopback into a pattern detector, no gap, three repetitions
    sr = '0; pulses = 0; done_cyc = -1; n = 0;
    start0 = 1'b1; rep_cnt0 = 4'd3;
    while (n < 60 && done_cyc < 0) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      n++;
      if (valid0) begin
        sr = {sr[5:0], out0};
        if (sr == pat) begin
          pulses++;
          pulse_at.push_back(n);
        end
      end
      if (done0) done_cyc = n;
    end
    check("lb_pulses", 32'(pulses), 32'd3);
    check("lb_done_cycle", 32'(done_cyc), 32'd22);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lb_pulse%0d", k), (k < pulse_at.size()) ? 32'(pulse_at[k]) : 32'hffff_ffff, 32'(7 * (k + 1)));
    end
    $display("loopback pulses=%0d done_cycle=%0d", pulses, done_cyc);

    // Asynchronous reset in the middle of a gap
    start = 1'b1; rep_cnt = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_reset_gap", 32'(act_main()), 32'(GAP_E));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 32'(act_main()), 32'(IDLE_E));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset%0d", k), 32'(act_main()), 32'(IDLE_E));
    end
    $display("reset mid-gap checked");

    // Randomized run against the burst model
    cur = IDLE_E;
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s = ($urandom_range(0, 5) == 0);
      a = ($urandom_range(0, 39) == 0);
      r = 4'($urandom_range(0, 15));
      start = s; abort = a; rep_cnt = r;
      @(posedge clk);
      #1;
      if (a) begin
        mq.delete();
        cur = IDLE_E;
      end else if (s && !cur[3]) begin
        build_burst(r);
        cur = mq.pop_front();
        $display("burst cyc=%0d reps=%0d", cyc, r);
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
      end else begin
        cur = IDLE_E;
      end
      check($sformatf("rand%0d", cyc), 32'(act_main()), 32'(cur));
    end
    start = 1'b0; abort = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
